// File: rtl/count_seq_pkg.sv
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared types, constants and helpers for the count sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_seq_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] prev);
        return prev + CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_seq_monitor_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter; an increment coincident with clr yields 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc) begin
            if (clr) begin
                cnt_q <= W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + W'(1);
            end
        end else if (clr) begin
            cnt_q <= '0;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/count_seq_monitor.sv
// ============================================================================
// Module      : count_seq_monitor
// Description : Checks a 2-bit counter stream advances by +1 mod 4; lock, fault,
//               wrap pulse, error and wrap statistics.
//               Optional wrap counter: COUNT_SEQ_MONITOR_WRAP_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_monitor
    import count_seq_pkg::*;
#(
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  q_in,
    input  logic              clr,
    output logic              locked,
    output logic              fault,
    output logic              wrap_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [3:0] C_LOCK_N = 4'(LOCK_N);

    state_t             state_q;
    logic [CNT_W-1:0]   prev_q;
    logic [3:0]         streak_q;
    logic [3:0]         streak_d;
    logic               locked_q;
    logic               fault_q;
    logic               wrap_pulse_q;
    logic               w_step_ok;
    logic               w_err_inc;
    logic               w_wrap_inc;

    assign w_step_ok  = (q_in == next_count(prev_q));
    assign w_err_inc  = en && (state_q == ST_LOCKED) && !w_step_ok;
    assign w_wrap_inc = en && (state_q == ST_LOCKED) && w_step_ok && (prev_q == '1);
    assign streak_d   = streak_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            streak_q     <= '0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            wrap_pulse_q <= w_wrap_inc;
            // A violation on the same edge as clr must leave fault set.
            if (w_err_inc) begin
                fault_q <= 1'b1;
            end else if (clr) begin
                fault_q <= 1'b0;
            end
            if (en) begin
                prev_q <= q_in;
                case (state_q)
                    ST_IDLE: begin
                        streak_q <= '0;
                        state_q  <= ST_ACQ;
                    end
                    ST_ACQ, ST_FAULT: begin
                        // streak is already 0 on FAULT entry, so the recovery sample
                        // is judged exactly like a fresh ACQ step.
                        if (w_step_ok) begin
                            if (streak_d == C_LOCK_N) begin
                                streak_q <= '0;
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                streak_q <= streak_d;
                                state_q  <= ST_ACQ;
                            end
                        end else begin
                            streak_q <= '0;
                            state_q  <= ST_ACQ;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_step_ok) begin
                            state_q  <= ST_FAULT;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W   (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err_inc),
        .clr (clr),
        .cnt (err_cnt)
    );

`ifdef COUNT_SEQ_MONITOR_WRAP_CNT_EN
    logic [WRAP_W-1:0] wrap_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else if (w_wrap_inc) begin
            wrap_cnt_q <= clr ? WRAP_W'(1) : wrap_cnt_q + WRAP_W'(1);
        end else if (clr) begin
            wrap_cnt_q <= '0;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    assign wrap_cnt = '0;
`endif

    assign locked     = locked_q;
    assign fault      = fault_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_monitor.sv
// ============================================================================
// Module      : tb_count_seq_monitor
// Description : Directed self-checking bench for count_seq_monitor (default and ERR_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] q_in;
    logic       clr;

    logic       locked,  fault,  wrap_pulse;
    logic [7:0] err_cnt, wrap_cnt;
    logic       locked2, fault2, wrap_pulse2;
    logic [1:0] err_cnt2;
    logic [7:0] wrap_cnt2;

    int checks;
    int errors;
    int wraps;
    int pulses;
    logic [1:0] p;
    logic [1:0] t;

    count_seq_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .q_in       (q_in),
        .clr        (clr),
        .locked     (locked),
        .fault      (fault),
        .wrap_pulse (wrap_pulse),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt)
    );

    count_seq_monitor #(.ERR_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .q_in       (q_in),
        .clr        (clr),
        .locked     (locked2),
        .fault      (fault2),
        .wrap_pulse (wrap_pulse2),
        .err_cnt    (err_cnt2),
        .wrap_cnt   (wrap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic e, input logic [1:0] q, input logic c);
        en   = e;
        q_in = q;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [1:0] q);
        tick(1'b1, q, 1'b0);
        p = q;
    endtask

    function automatic logic [31:0] exp_wrap(input int n);
`ifdef COUNT_SEQ_MONITOR_WRAP_CNT_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        checks = 0; errors = 0; wraps = 0; pulses = 0; p = 2'd0;
        rst = 1'b1; en = 1'b0; q_in = 2'd0; clr = 1'b0;

        // reset dominates en/clr
        tick(1'b1, 2'd3, 1'b1);
        tick(1'b1, 2'd1, 1'b0);
        chk("rst_locked", locked, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pulse", wrap_pulse, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_wrap", wrap_cnt, 0);
        rst = 1'b0;

        // capture + 3 correct steps: not yet locked; 4th step locks
        for (int i = 0; i < 4; i++) begin
            feed(2'(i));
            chk("acq_unlocked", locked, 0);
        end
        feed(2'd0);
        chk("lock_rise", locked, 1);
        chk("lock_no_pulse", wrap_pulse, 0);
        chk("lock_fault", fault, 0);
        for (int i = 1; i < 4; i++) begin
            feed(2'(i));
            chk("locked_no_pulse", wrap_pulse, 0);
        end
        feed(2'd0);
        wraps++;
        chk("wrap_pulse_hi", wrap_pulse, 1);
        chk("wrap_cnt_1", wrap_cnt, exp_wrap(wraps));
        feed(2'd1);
        chk("wrap_pulse_lo", wrap_pulse, 0);

        // violation 1 -> 2 -> 0
        feed(2'd2);
        feed(2'd0);
        chk("viol_fault", fault, 1);
        chk("viol_locked", locked, 0);
        chk("viol_err", err_cnt, 1);
        chk("viol_err2", err_cnt2, 1);
        chk("viol_pulse", wrap_pulse, 0);

        // recovery sample counts as the first ACQ step
        feed(2'd1); chk("rec_1", locked, 0);
        feed(2'd2); chk("rec_2", locked, 0);
        feed(2'd3); chk("rec_3", locked, 0);
        feed(2'd0);
        chk("relock", locked, 1);
        chk("relock_pulse", wrap_pulse, 0);
        chk("relock_fault", fault, 1);

        // saturation: 4 more violations, each with relock
        for (int k = 2; k <= 5; k++) begin
            t = p + 2'd2;
            feed(t);
            chk("sat_err", err_cnt, k);
            chk("sat_err2", err_cnt2, (k > 3) ? 3 : k);
            chk("sat_locked", locked, 0);
            for (int j = 0; j < 4; j++) begin
                t = p + 2'd1;
                feed(t);
            end
            chk("sat_relock", locked, 1);
        end

        // clr alone
        tick(1'b0, 2'd0, 1'b1);
        wraps = 0;
        chk("clr_err", err_cnt, 0);
        chk("clr_err2", err_cnt2, 0);
        chk("clr_fault", fault, 0);
        chk("clr_locked", locked, 1);
        chk("clr_wrap", wrap_cnt, 0);

        // en low: hold, garbage ignored, prev retained
        t = p + 2'd2;
        tick(1'b0, t, 1'b0);
        chk("hold_locked", locked, 1);
        chk("hold_pulse", wrap_pulse, 0);
        t = p + 2'd1;
        feed(t);
        chk("hold_prev", locked, 1);
        chk("hold_fault", fault, 0);

        // clr coincident with violation
        t = p + 2'd2;
        feed(t);
        chk("pre_err", err_cnt, 1);
        for (int j = 0; j < 4; j++) begin
            t = p + 2'd1;
            feed(t);
        end
        t = p + 2'd2;
        tick(1'b1, t, 1'b1);
        p = t;
        chk("clrv_fault", fault, 1);
        chk("clrv_err", err_cnt, 1);
        chk("clrv_err2", err_cnt2, 1);
        chk("clrv_locked", locked, 0);

        // relock and land on prev=3, then clr coincident with wrap
        for (int j = 0; j < 4; j++) begin
            t = p + 2'd1;
            feed(t);
        end
        chk("clrw_relock", locked, 1);
        for (int j = 0; j < 3 && p != 2'd3; j++) begin
            t = p + 2'd1;
            feed(t);
        end
        tick(1'b1, 2'd0, 1'b1);
        p = 2'd0;
        wraps = 1;
        chk("clrw_pulse", wrap_pulse, 1);
        chk("clrw_wrap", wrap_cnt, exp_wrap(wraps));
        chk("clrw_fault", fault, 0);
        chk("clrw_err", err_cnt, 0);

        // 10 wraps
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            t = p + 2'd1;
            feed(t);
            chk("run_pulse", wrap_pulse, (p == 2'd0) ? 1 : 0);
            if (wrap_pulse === 1'b1) pulses++;
        end
        wraps += 10;
        chk("run_pulses", pulses, 10);
        chk("run_wrap", wrap_cnt, exp_wrap(wraps));

        // en low between 3 and 0 still yields one wrap
        feed(2'd1); feed(2'd2); feed(2'd3);
        tick(1'b0, 2'd0, 1'b0);
        chk("gap_pulse_lo", wrap_pulse, 0);
        feed(2'd0);
        wraps++;
        chk("gap_pulse_hi", wrap_pulse, 1);
        chk("gap_wrap", wrap_cnt, exp_wrap(wraps));

        // rst mid-ACQ with streak 3
        t = p + 2'd2;
        feed(t);
        for (int j = 0; j < 3; j++) begin
            t = p + 2'd1;
            feed(t);
        end
        chk("mid_unlocked", locked, 0);
        rst = 1'b1;
        t = p + 2'd1;
        tick(1'b1, t, 1'b0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_pulse", wrap_pulse, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_wrap", wrap_cnt, 0);
        rst = 1'b0;

        // 50% en: first sample 2 only captured; lock on 5th enabled edge
        for (int i = 0; i < 5; i++) begin
            t = 2'(i + 2);
            tick(1'b0, t + 2'd2, 1'b0);
            chk("tog_off", locked, 0);
            feed(t);
            chk("tog_on", locked, (i == 4) ? 1 : 0);
            chk("tog_pulse", wrap_pulse, 0);
        end
        chk("tog_fault", fault, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
